// File: rtl/chacha_pkg.sv
// Shared constants and types for the ChaCha keystream scheduler.
// Field widths match the keystream unit's configuration and output ports.
package chacha_pkg;

    localparam int CHACHA_KEY_W   = 256;
    localparam int CHACHA_NONCE_W = 96;
    localparam int CHACHA_CTR_W   = 32;
    localparam int CHACHA_BLK_W   = 512;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } sched_state_t;

    // Channel index width; a single-channel build still carries a 1-bit tag.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chacha_ks_sched_if.sv
// Keystream output stream (scheduler -> consumer) and keystream unit bus
// (scheduler -> chacha_keystream_unit).
interface chacha_ks_sched_if #(
    parameter int CW = 1
);
    import chacha_pkg::*;

    logic                    out_valid;
    logic                    out_ready;
    logic [CW-1:0]           out_ch;
    logic [CHACHA_BLK_W-1:0] out_data;

    modport master (output out_valid, out_ch, out_data, input out_ready);
    modport slave  (input out_valid, out_ch, out_data, output out_ready);
endinterface

interface chacha_ku_if;
    import chacha_pkg::*;

    logic                      ku_cfg_we;
    logic [CHACHA_KEY_W-1:0]   ku_key;
    logic [CHACHA_NONCE_W-1:0] ku_nonce;
    logic [CHACHA_CTR_W-1:0]   ku_ctr;
    logic                      ku_req;
    logic                      ku_valid;
    logic [CHACHA_BLK_W-1:0]   ku_data;

    modport master (output ku_cfg_we, ku_key, ku_nonce, ku_ctr, ku_req,
                    input  ku_valid, ku_data);
    modport slave  (input  ku_cfg_we, ku_key, ku_nonce, ku_ctr, ku_req,
                    output ku_valid, ku_data);
endinterface

// File: rtl/chacha_ks_sched_rr_arbiter.sv
// Pointer-based round-robin arbiter: combinational pick of the first request
// above the pointer, pointer updated on the caller's commit strobe.
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         upd,
    input  logic [W-1:0] upd_idx,
    output logic         any,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    logic [W-1:0] ptr_reg;

    // Pointer starts at the last channel so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= W'(N - 1);
        end else if (upd) begin
            ptr_reg <= upd_idx;
        end
    end

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (int'(ptr_reg) + k) % N;
            if (!any && req[c]) begin
                any = 1'b1;
                idx = W'(c);
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign onehot[gi] = any && (idx == W'(gi));
    end

endmodule

// File: rtl/chacha_ks_sched.sv
// Shares one ChaCha keystream unit among NCH channels: round-robin grant,
// per-channel key/nonce/counter contexts, one 512-bit block per grant.
module chacha_ks_sched
    import chacha_pkg::*;
#(
    parameter int  NCH     = 2,
    parameter int  TIMEOUT = 1024,
    localparam int CW      = ch_w(NCH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ctx_we,
    input  logic [CW-1:0]             ctx_sel,
    input  logic [CHACHA_KEY_W-1:0]   ctx_key,
    input  logic [CHACHA_NONCE_W-1:0] ctx_nonce,
    input  logic [CHACHA_CTR_W-1:0]   ctx_ctr,
    input  logic [NCH-1:0]            req,
    output logic [NCH-1:0]            gnt,
    output logic [NCH-1:0]            exhausted,
    output logic                      err_timeout,
    chacha_ks_sched_if.master         stream,
    chacha_ku_if.master               ku
);

    localparam int WD_W = $clog2(TIMEOUT);

    sched_state_t state_reg, state_next;
    logic [CW-1:0] cur_reg;
    logic [WD_W-1:0] wd_reg;
    logic err_reg;

    logic [CHACHA_KEY_W-1:0]   key_reg   [NCH];
    logic [CHACHA_NONCE_W-1:0] nonce_reg [NCH];
    logic [CHACHA_CTR_W-1:0]   ctr_reg   [NCH];
    logic                      exh_reg   [NCH];

    logic [CHACHA_KEY_W-1:0]   cfg_key_reg;
    logic [CHACHA_NONCE_W-1:0] cfg_nonce_reg;
    logic [CHACHA_CTR_W-1:0]   cfg_ctr_reg;
    logic [CHACHA_BLK_W-1:0]   data_reg;

    logic [NCH-1:0] eligible;
    logic           arb_any;
    logic [CW-1:0]  arb_idx;
    logic [NCH-1:0] arb_onehot;
    logic           grant;
    logic           accept;
    logic           wd_hit;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_elig
        assign eligible[gi]  = req[gi] && !exh_reg[gi];
        assign exhausted[gi] = exh_reg[gi];
    end

    rr_arbiter #(
        .N (NCH),
        .W (CW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (eligible),
        .upd     (accept),
        .upd_idx (cur_reg),
        .any     (arb_any),
        .idx     (arb_idx),
        .onehot  (arb_onehot)
    );

    assign grant  = (state_reg == ST_IDLE) && arb_any;
    assign accept = (state_reg == ST_OUT) && stream.out_ready;
    assign wd_hit = (state_reg == ST_WAIT) && !ku.ku_valid
                    && (wd_reg == WD_W'(TIMEOUT - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (arb_any) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_WAIT;
            ST_WAIT: begin
                if (ku.ku_valid) begin
                    state_next = ST_OUT;
                end else if (wd_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_OUT:  if (stream.out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from state so reset drops them immediately
    always_comb begin
        ku.ku_cfg_we     = (state_reg == ST_LOAD);
        ku.ku_req        = (state_reg == ST_WAIT);
        stream.out_valid = (state_reg == ST_OUT);
        for (int i = 0; i < NCH; i++) begin
            gnt[i] = accept && (cur_reg == CW'(i));
        end
    end

    assign ku.ku_key       = cfg_key_reg;
    assign ku.ku_nonce     = cfg_nonce_reg;
    assign ku.ku_ctr       = cfg_ctr_reg;
    assign stream.out_ch   = cur_reg;
    assign stream.out_data = data_reg;
    assign err_timeout     = err_reg;

    // Config is snapshotted at grant, so later context writes can't disturb
    // the block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_reg       <= '0;
            cfg_key_reg   <= '0;
            cfg_nonce_reg <= '0;
            cfg_ctr_reg   <= '0;
            data_reg      <= '0;
            wd_reg        <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (grant) begin
                cur_reg       <= arb_idx;
                cfg_key_reg   <= key_reg[arb_idx];
                cfg_nonce_reg <= nonce_reg[arb_idx];
                cfg_ctr_reg   <= ctr_reg[arb_idx];
            end
            if (state_reg == ST_WAIT && ku.ku_valid) begin
                data_reg <= ku.ku_data;
            end
            wd_reg <= (state_reg == ST_WAIT) ? wd_reg + 1'b1 : '0;
            if (wd_hit) begin
                err_reg <= 1'b1;
            end else if (ctx_we) begin
                err_reg <= 1'b0;
            end
        end
    end

    // Per-channel contexts; a host write overrides the post-delivery bump.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ctx
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                key_reg[gi]   <= '0;
                nonce_reg[gi] <= '0;
                ctr_reg[gi]   <= '0;
                exh_reg[gi]   <= 1'b0;
            end else if (ctx_we && ctx_sel == CW'(gi)) begin
                key_reg[gi]   <= ctx_key;
                nonce_reg[gi] <= ctx_nonce;
                ctr_reg[gi]   <= ctx_ctr;
                exh_reg[gi]   <= 1'b0;
            end else if (accept && cur_reg == CW'(gi)) begin
                if (&ctr_reg[gi]) begin
                    exh_reg[gi] <= 1'b1;
                end else begin
                    ctr_reg[gi] <= ctr_reg[gi] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chacha_ks_sched.sv
// Directed bench for chacha_ks_sched with a simple fixed-latency keystream unit model.
module tb_chacha_ks_sched;
    import chacha_pkg::*;

    localparam int NCH     = 2;
    localparam int TIMEOUT = 64;
    localparam int CW      = 1;
    localparam int LAT     = 3;
    localparam logic [127:0] PAD = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    localparam logic [255:0] K0 = {8{32'h1111_0000}};
    localparam logic [95:0]  N0 = 96'h0000_00aa_0000_00bb_0000_00cc;
    localparam logic [255:0] K1 = {8{32'h2222_ffff}};
    localparam logic [95:0]  N1 = 96'h1234_5678_9abc_def0_0f0f_0f0f;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           ctx_we = 1'b0;
    logic [CW-1:0]  ctx_sel = '0;
    logic [255:0]   ctx_key = '0;
    logic [95:0]    ctx_nonce = '0;
    logic [31:0]    ctx_ctr = '0;
    logic [NCH-1:0] req = '0;
    logic [NCH-1:0] gnt;
    logic [NCH-1:0] exhausted;
    logic           err_timeout;

    chacha_ks_sched_if #(.CW(CW)) st_if ();
    chacha_ku_if                  ku_if ();

    chacha_ks_sched #(
        .NCH     (NCH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctx_we      (ctx_we),
        .ctx_sel     (ctx_sel),
        .ctx_key     (ctx_key),
        .ctx_nonce   (ctx_nonce),
        .ctx_ctr     (ctx_ctr),
        .req         (req),
        .gnt         (gnt),
        .exhausted   (exhausted),
        .err_timeout (err_timeout),
        .stream      (st_if.master),
        .ku          (ku_if.master)
    );

    // Keystream unit model: answers ks_req after LAT cycles with a block
    // built from the configuration it was given.
    logic       model_en = 1'b1;
    logic [7:0] model_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_cnt       <= '0;
            ku_if.ku_valid  <= 1'b0;
            ku_if.ku_data   <= '0;
        end else begin
            ku_if.ku_valid <= 1'b0;
            if (ku_if.ku_req && !ku_if.ku_valid && model_en) begin
                if (model_cnt == 8'(LAT - 1)) begin
                    ku_if.ku_valid <= 1'b1;
                    ku_if.ku_data  <= {ku_if.ku_key, ku_if.ku_nonce, ku_if.ku_ctr, PAD};
                    model_cnt      <= '0;
                end else begin
                    model_cnt <= model_cnt + 1'b1;
                end
            end else begin
                model_cnt <= '0;
            end
        end
    end

    int         gnt_cnt = 0;
    int         cfg_cnt = 0;
    logic [31:0] last_cfg_ctr = '0;
    always begin
        @(negedge clk);
        #2;
        if (gnt != '0) gnt_cnt++;
        if (ku_if.ku_cfg_we) begin
            cfg_cnt++;
            last_cfg_ctr = ku_if.ku_ctr;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] blk(input logic [255:0] k, input logic [95:0] n,
                                         input logic [31:0] c);
        return {k, n, c, PAD};
    endfunction

    task automatic write_ctx(input int ch, input logic [255:0] k, input logic [95:0] n,
                             input logic [31:0] c);
        ctx_sel   = CW'(ch);
        ctx_key   = k;
        ctx_nonce = n;
        ctx_ctr   = c;
        ctx_we    = 1'b1;
        @(negedge clk);
        ctx_we    = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!st_if.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("out_valid_seen", 512'(st_if.out_valid), 512'(1'b1));
    endtask

    task automatic accept_block(input int ch, input logic [255:0] k, input logic [95:0] n,
                                input logic [31:0] c);
        logic [NCH-1:0] ge;
        ge     = '0;
        ge[ch] = 1'b1;
        check_eq("out_ch", 512'(st_if.out_ch), 512'(ch));
        check_eq("out_data", st_if.out_data, blk(k, n, c));
        st_if.out_ready = 1'b1;
        #1;
        check_eq("gnt", 512'(gnt), 512'(ge));
        $display("block ch=%0d ctr=%08h gnt=%b", ch, c, gnt);
        @(negedge clk);
        st_if.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int          n;
        int          c0;
        int          g0;
        int          rc;
        bit          stable;
        logic [511:0] d0;

        st_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_out_valid", 512'(st_if.out_valid), '0);
        check_eq("rst_gnt", 512'(gnt), '0);
        check_eq("rst_exhausted", 512'(exhausted), '0);
        check_eq("rst_err", 512'(err_timeout), '0);
        check_eq("rst_cfg_we", 512'(ku_if.ku_cfg_we), '0);
        check_eq("rst_ku_req", 512'(ku_if.ku_req), '0);
        check_eq("rst_ku_ctr", 512'(ku_if.ku_ctr), '0);
        check_eq("rst_ku_key", 512'(ku_if.ku_key), '0);
        check_eq("rst_out_ch", 512'(st_if.out_ch), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single channel, latency, and counter advance
        write_ctx(0, '0, '0, 32'd1);
        req = 2'b01;
        @(negedge clk);
        check_eq("cfg_we_t1", 512'(ku_if.ku_cfg_we), 512'(1'b1));
        check_eq("ku_ctr_t1", 512'(ku_if.ku_ctr), 512'(32'd1));
        @(negedge clk);
        check_eq("ku_req_t2", 512'(ku_if.ku_req), 512'(1'b1));
        check_eq("cfg_we_t2", 512'(ku_if.ku_cfg_we), '0);
        wait_valid(n);
        check_eq("req_to_valid", 512'(n + 2), 512'(3 + LAT));
        accept_block(0, '0, '0, 32'd1);
        check_eq("cfg_cnt_1", 512'(cfg_cnt), 512'(1));
        wait_valid(n);
        req = 2'b00;
        accept_block(0, '0, '0, 32'd2);
        check_eq("cfg_cnt_2", 512'(cfg_cnt), 512'(2));
        check_eq("last_cfg_ctr", 512'(last_cfg_ctr), 512'(32'd2));

        // Fairness over two channels
        do_reset();
        write_ctx(0, K0, N0, 32'd10);
        write_ctx(1, K1, N1, 32'd100);
        req = 2'b11;
        wait_valid(n);
        accept_block(0, K0, N0, 32'd10);
        wait_valid(n);
        accept_block(1, K1, N1, 32'd100);
        wait_valid(n);
        accept_block(0, K0, N0, 32'd11);
        wait_valid(n);
        req = 2'b00;
        accept_block(1, K1, N1, 32'd101);

        // Backpressure
        req = 2'b01;
        wait_valid(n);
        req = 2'b00;
        c0 = cfg_cnt;
        d0 = st_if.out_data;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!st_if.out_valid || st_if.out_data !== d0) stable = 1'b0;
        end
        check_eq("bp_stable", 512'(stable), 512'(1'b1));
        check_eq("bp_no_cfg", 512'(cfg_cnt), 512'(c0));
        g0 = gnt_cnt;
        accept_block(0, K0, N0, 32'd12);
        repeat (3) @(negedge clk);
        check_eq("bp_one_gnt", 512'(gnt_cnt), 512'(g0 + 1));

        // Counter wrap on channel 1
        write_ctx(1, K1, N1, 32'hFFFF_FFFF);
        req = 2'b10;
        wait_valid(n);
        accept_block(1, K1, N1, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        check_eq("wrap_exhausted", 512'(exhausted), 512'(2'b10));
        c0 = cfg_cnt;
        repeat (15) @(negedge clk);
        check_eq("wrap_blocked", 512'(cfg_cnt), 512'(c0));
        check_eq("wrap_no_valid", 512'(st_if.out_valid), '0);
        write_ctx(1, K1, N1, 32'd0);
        check_eq("wrap_cleared", 512'(exhausted), '0);
        wait_valid(n);
        req = 2'b00;
        accept_block(1, K1, N1, 32'd0);

        // Watchdog timeout
        model_en = 1'b0;
        g0 = gnt_cnt;
        req = 2'b01;
        n = 0;
        rc = 0;
        while (!err_timeout && n < 300) begin
            @(negedge clk);
            n++;
            if (ku_if.ku_req) rc++;
        end
        req = 2'b00;
        check_eq("to_err", 512'(err_timeout), 512'(1'b1));
        check_eq("to_wait_cycles", 512'(rc), 512'(TIMEOUT));
        check_eq("to_req_drop", 512'(ku_if.ku_req), '0);
        repeat (3) @(negedge clk);
        check_eq("to_no_gnt", 512'(gnt_cnt), 512'(g0));
        model_en = 1'b1;
        req = 2'b01;
        wait_valid(n);
        req = 2'b00;
        accept_block(0, K0, N0, 32'd13);
        check_eq("to_sticky", 512'(err_timeout), 512'(1'b1));
        write_ctx(0, K0, N0, 32'd13);
        check_eq("to_cleared", 512'(err_timeout), '0);

        // Reset in the middle of WAIT
        write_ctx(1, K1, N1, 32'hFFFF_FFFF);
        req = 2'b10;
        wait_valid(n);
        req = 2'b00;
        accept_block(1, K1, N1, 32'hFFFF_FFFF);
        model_en = 1'b0;
        req = 2'b01;
        repeat (3) @(negedge clk);
        check_eq("mid_ku_req", 512'(ku_if.ku_req), 512'(1'b1));
        check_eq("mid_exhausted", 512'(exhausted), 512'(2'b10));
        rst_n = 1'b0;
        #1;
        check_eq("async_ku_req", 512'(ku_if.ku_req), '0);
        repeat (2) @(negedge clk);
        check_eq("mid_rst_exh", 512'(exhausted), '0);
        check_eq("mid_rst_valid", 512'(st_if.out_valid), '0);
        check_eq("mid_rst_cfg_we", 512'(ku_if.ku_cfg_we), '0);
        check_eq("mid_rst_key", 512'(ku_if.ku_key), '0);
        req = 2'b00;
        rst_n = 1'b1;
        model_en = 1'b1;
        @(negedge clk);
        req = 2'b01;
        wait_valid(n);
        req = 2'b00;
        accept_block(0, '0, '0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chacha_ks_sched.md
# chacha_ks_sched

Multi-channel scheduler that shares one `chacha_keystream_unit` among NCH independent cipher channels. Holds per-channel key/nonce/block-counter contexts and arbitrates channel requests round-robin. For each grant it reloads the unit's configuration and requests exactly one 512-bit keystream block. It then returns the block with its channel tag over a valid/ready output. Sits between the per-channel encrypt/decrypt datapaths and the single keystream unit.

## Interface
- NCH, 2: number of channels, 1..4.
- TIMEOUT, 1024: cycles to wait for `ks_valid` before aborting, ≥64.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ctx_we  in  1  write the context of channel `ctx_sel`.
- ctx_sel  in  $clog2(NCH) (min 1)  target channel.
- ctx_key  in  256  key.
- ctx_nonce  in  96  nonce.
- ctx_ctr  in  32  initial block counter.
- req  in  NCH  level request per channel; one block per grant.
- gnt  out  NCH  one-hot pulse; channel's block was accepted at the output.
- out_valid  out  1  keystream block available.
- out_ready  in  1  consumer accepts the block.
- out_ch  out  $clog2(NCH) (min 1)  channel tag of `out_data`.
- out_data  out  512  keystream block.
- exhausted  out  NCH  channel counter wrapped; channel is blocked until its context is rewritten.
- err_timeout  out  1  sticky; unit failed to respond. Cleared by `ctx_we`.
- ku_cfg_we  out  1  to unit `cfg_we`.
- ku_key / ku_nonce / ku_ctr  out  256/96/32  to unit `chacha_key`/`chacha_nonce`/`chacha_ctr_init`.
- ku_req  out  1  to unit `ks_req`.
- ku_valid  in  1  from unit `ks_valid`.
- ku_data  in  512  from unit `ks_data`.

## Operation
- Reset values:
  - all outputs 0; FSM in IDLE.
  - all contexts 0; `exhausted` 0.
  - RR pointer at channel NCH-1, so channel 0 has first priority.
- Eligibility: channel i is eligible when `req[i]` is high and `exhausted[i]` is low.
- FSM:
  - IDLE:
    - if any channel is eligible, pick the first eligible channel searching upward from pointer+1 (mod NCH).
    - latch it as `cur`; go to LOAD.
  - LOAD:
    - `ku_cfg_we`=1 for exactly one cycle.
    - `ku_key`/`ku_nonce`/`ku_ctr` driven from the registered context of `cur`; these are held stable through WAIT.
    - go to WAIT.
  - WAIT:
    - `ku_req`=1 and the watchdog counts.
    - when `ku_valid`=1: capture `ku_data` into `out_data`; `ku_req` falls on that edge; go to OUT.
    - when the watchdog reaches TIMEOUT-1 without `ku_valid`: set `err_timeout`; drop `ku_req`; go to IDLE. No grant, counter unchanged.
  - OUT:
    - `out_valid`=1, `out_ch`=`cur`; `out_data` is stable until accepted.
    - when `out_ready`: pulse `gnt[cur]` for one cycle; `ctr[cur]` += 1; pointer=`cur`; go to IDLE.
    - if the counter was 0xFFFFFFFF: do not wrap-increment; set `exhausted[cur]` instead. The block itself is still delivered.
- Context write:
  - `ctx_we` overwrites key, nonce and ctr of `ctx_sel` and clears `exhausted[ctx_sel]`.
  - this takes priority over the OUT-state counter increment in the same cycle; the written `ctx_ctr` wins.
  - writing the channel currently in WAIT/OUT does not affect the in-flight block (`ku_*` config is already latched).
- `req` deasserting after a grant decision does not cancel the block; it is still delivered and `gnt` still pulses.
- Out-of-sequence `ku_valid` (outside WAIT) is ignored.
- NCH=1: arbitration is trivial; `out_ch` is always 0.

## Timing
- Arbitration is registered: `req` seen in IDLE at edge t → `ku_cfg_we` high in cycle t+1 → `ku_req` high from t+2.
- `out_valid` rises the cycle after `ku_valid` is sampled.
- Request-to-`out_valid` latency = 3 + unit latency.
- Back-to-back: after `gnt`, IDLE takes one cycle, so the minimum grant spacing is unit latency + 4.
- Reset asserted mid-operation: all state clears immediately; `ku_req`/`ku_cfg_we` drop asynchronously; contexts are lost.

## Structure
- Shared package `chacha_pkg`:
  - `CHACHA_KEY_W`=256, `CHACHA_NONCE_W`=96, `CHACHA_CTR_W`=32, `CHACHA_BLK_W`=512.
  - FSM state encoding constants.
- One natural sub-module: `rr_arbiter` (NCH-wide, pointer-based, combinational grant plus registered pointer update), reusable elsewhere.
- Context storage is flat registers; no RAM.

## Test plan
- Single channel: ch0 ctx key=0, nonce=0, ctr=1; raise req[0] → one `ku_cfg_we` with `ku_ctr`=1, `out_ch`=0, `gnt`=0b01; next block loads `ku_ctr`=2.
- Fairness: NCH=2, req=0b11 held for 4 grants → `gnt` sequence 01,10,01,10; each channel's ctr advances by exactly 2.
- Backpressure: hold `out_ready`=0 for 20 cycles → `out_valid` and `out_data` stable; no new `ku_cfg_we`; single `gnt` on release.
- Wrap: ch1 ctr=0xFFFFFFFF, req[1] → block delivered, `exhausted`=0b10; ch1 is never granted again; `ctx_we` ch1 ctr=0 → `exhausted` clears and service resumes at ctr 0.
- Timeout: unit model never asserts ks_valid, TIMEOUT=64 → `err_timeout`=1 after 64 WAIT cycles, no `gnt`, ctr unchanged; the next request is serviced normally.
- Reset mid-WAIT: `rst_n` low for 2 cycles → all outputs 0, contexts 0, `exhausted`=0.
